// File: rtl/lpc_preemphasis.sv
// First-order pre-emphasis filter y = x - alpha*p on an AXI-Stream-like sample
// stream, with LPC frame tracking (index, LAST generation, length errors).
module lpc_preemphasis #(
  parameter int DATA_W      = 16,
  parameter int FRAME_SIZE  = 1920,
  parameter int ALPHA_SHIFT = 4
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  input  logic                     IN_VALID,
  output logic                     IN_READY,
  input  logic signed [DATA_W-1:0] IN_SAMPLE,
  input  logic                     IN_LAST,
  output logic                     OUT_VALID,
  input  logic                     OUT_READY,
  output logic signed [DATA_W-1:0] OUT_SAMPLE,
  output logic                     OUT_LAST,
  output logic                     FRAME_ERR,
  output logic [15:0]              FRAME_CNT
);

  localparam int SW = DATA_W + 2;
  localparam logic [10:0] LAST_IDX = 11'(FRAME_SIZE - 1);
  localparam logic signed [SW-1:0] SAT_MAX = SW'((2 ** (DATA_W - 1)) - 1);
  localparam logic signed [SW-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic {SOF, MID} state_t;

  state_t                     r_state;
  logic [10:0]                r_idx;
  logic signed [DATA_W-1:0]   r_hist;
  logic                       r_out_valid;
  logic signed [DATA_W-1:0]   r_out_sample;
  logic                       r_out_last;
  logic                       r_err;
  logic [15:0]                r_cnt;

  logic                       w_acc;
  logic                       w_at_end;
  logic                       w_last;
  logic signed [SW-1:0]       w_x;
  logic signed [SW-1:0]       w_p;
  logic signed [SW-1:0]       w_leak;
  logic signed [SW-1:0]       w_diff;
  logic signed [DATA_W-1:0]   w_y;

  assign IN_READY   = (!r_out_valid || OUT_READY) && !ARESET;
  assign w_acc      = IN_VALID && IN_READY;
  assign w_at_end   = (r_idx == LAST_IDX);
  assign w_last     = IN_LAST || w_at_end;

  assign OUT_VALID  = r_out_valid;
  assign OUT_SAMPLE = r_out_sample;
  assign OUT_LAST   = r_out_last;
  assign FRAME_ERR  = r_err;
  assign FRAME_CNT  = r_cnt;

  // Two guard bits cover the worst case x - alpha*p before saturation.
  always_comb begin
    w_x    = {{2{IN_SAMPLE[DATA_W-1]}}, IN_SAMPLE};
    w_p    = {{2{r_hist[DATA_W-1]}}, r_hist};
    w_leak = w_p - (w_p >>> ALPHA_SHIFT);
    w_diff = (r_state == SOF) ? w_x : (w_x - w_leak);
    if (w_diff > SAT_MAX)      w_y = SAT_MAX[DATA_W-1:0];
    else if (w_diff < SAT_MIN) w_y = SAT_MIN[DATA_W-1:0];
    else                       w_y = w_diff[DATA_W-1:0];
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      r_state      <= SOF;
      r_idx        <= '0;
      r_hist       <= '0;
      r_out_valid  <= 1'b0;
      r_out_sample <= '0;
      r_out_last   <= 1'b0;
      r_err        <= 1'b0;
      r_cnt        <= '0;
    end else begin
      r_err <= 1'b0;
      if (r_out_valid && OUT_READY && r_out_last)
        r_cnt <= r_cnt + 16'd1;
      if (w_acc) begin
        r_out_valid  <= 1'b1;
        r_out_sample <= w_y;
        r_out_last   <= w_last;
        r_hist       <= IN_SAMPLE;
        // Short frame (early LAST) or missing LAST at the nominal end.
        r_err        <= (IN_LAST != w_at_end);
        if (w_last) begin
          r_idx   <= '0;
          r_state <= SOF;
        end else begin
          r_idx   <= r_idx + 11'd1;
          r_state <= MID;
        end
      end else if (OUT_READY) begin
        r_out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_lpc_preemphasis.sv
// Directed bench for lpc_preemphasis: reset, full frame, saturation,
// backpressure, short frame and missing-LAST cases.
module tb_lpc_preemphasis;

  logic               ACLK = 1'b0;
  logic               ARESET;
  logic               IN_VALID;
  logic               IN_READY;
  logic signed [15:0] IN_SAMPLE;
  logic               IN_LAST;
  logic               OUT_VALID;
  logic               OUT_READY;
  logic signed [15:0] OUT_SAMPLE;
  logic               OUT_LAST;
  logic               FRAME_ERR;
  logic [15:0]        FRAME_CNT;

  int ncmp = 0;
  int nfail = 0;
  int err_cnt = 0;
  logic signed [15:0] oq[$];
  bit                 lq[$];

  lpc_preemphasis #(.DATA_W(16), .FRAME_SIZE(1920), .ALPHA_SHIFT(4)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_SAMPLE(IN_SAMPLE), .IN_LAST(IN_LAST),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY), .OUT_SAMPLE(OUT_SAMPLE), .OUT_LAST(OUT_LAST),
    .FRAME_ERR(FRAME_ERR), .FRAME_CNT(FRAME_CNT)
  );

  always #5 ACLK = ~ACLK;

  // Record every output transfer and every error pulse.
  always @(posedge ACLK) begin
    if (!ARESET && OUT_VALID && OUT_READY) begin
      oq.push_back(OUT_SAMPLE);
      lq.push_back(OUT_LAST);
    end
    if (!ARESET && FRAME_ERR) err_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  function automatic logic signed [15:0] qat(input int i);
    if (i < oq.size()) return oq[i];
    return 16'sh7ead;
  endfunction

  function automatic int nlast();
    int n = 0;
    for (int i = 0; i < lq.size(); i++) if (lq[i]) n++;
    return n;
  endfunction

  task automatic do_reset();
    @(negedge ACLK);
    ARESET = 1'b1; IN_VALID = 1'b0; IN_LAST = 1'b0; OUT_READY = 1'b1;
    repeat (2) @(negedge ACLK);
    ARESET = 1'b0;
    oq.delete(); lq.delete(); err_cnt = 0;
  endtask

  // Called at a negedge; returns at the negedge after acceptance.
  task automatic send(input logic signed [15:0] x, input logic l);
    int t = 0;
    IN_VALID = 1'b1; IN_SAMPLE = x; IN_LAST = l;
    do begin
      @(posedge ACLK); t++;
    end while (!IN_READY && t < 100);
    if (t >= 100) begin
      ncmp++; nfail++;
      $display("FAIL send_timeout sample %0d never accepted", x);
    end
    @(negedge ACLK);
    IN_VALID = 1'b0; IN_LAST = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (OUT_VALID && t < 50) begin @(negedge ACLK); t++; end
    if (t >= 50) begin
      ncmp++; nfail++;
      $display("FAIL drain_timeout OUT_VALID still high");
    end
    @(negedge ACLK);
  endtask

  task automatic test_reset();
    @(negedge ACLK);
    ARESET = 1'b1; IN_VALID = 1'b1; IN_SAMPLE = 16'sd1234; IN_LAST = 1'b0; OUT_READY = 1'b1;
    repeat (3) begin
      @(posedge ACLK); #1;
      ncmp++;
      if ({IN_READY, OUT_VALID, FRAME_ERR, OUT_LAST} !== 4'b0000 || FRAME_CNT !== 16'd0 || OUT_SAMPLE !== 16'sd0) begin
        nfail++;
        $display("FAIL reset_hold got rdy=%b vld=%b err=%b last=%b cnt=%0d smp=%0d want all 0",
                 IN_READY, OUT_VALID, FRAME_ERR, OUT_LAST, FRAME_CNT, OUT_SAMPLE);
      end
    end
    @(negedge ACLK);
    IN_VALID = 1'b0; ARESET = 1'b0;
    oq.delete(); lq.delete(); err_cnt = 0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    send(16'sd1000, 1'b0); send(16'sd1000, 1'b0); send(16'sd1000, 1'b0);
    do_reset();
    send(16'sd1600, 1'b0);
    drain();
    ncmp++;
    if (oq.size() !== 1 || qat(0) !== 16'sd1600) begin
      nfail++;
      $display("FAIL reset_mid got n=%0d y=%0d want n=1 y=1600", oq.size(), qat(0));
    end
    ncmp++;
    if (FRAME_CNT !== 16'd0) begin
      nfail++; $display("FAIL reset_mid_cnt got %0d want 0", FRAME_CNT);
    end
  endtask

  task automatic test_full_frame();
    int bad = 0;
    do_reset();
    for (int i = 1; i <= 1920; i++) send(16'sd1600, i == 1920);
    drain();
    for (int i = 1; i < 1920; i++) if (qat(i) !== 16'sd100) bad++;
    ncmp++;
    if (oq.size() !== 1920 || qat(0) !== 16'sd1600) begin
      nfail++; $display("FAIL frame_first got n=%0d y0=%0d want n=1920 y0=1600", oq.size(), qat(0));
    end
    ncmp++;
    if (bad !== 0) begin
      nfail++; $display("FAIL frame_body got %0d samples not 100 want 0", bad);
    end
    ncmp++;
    if (nlast() !== 1 || lq.size() != 1920 || !lq[1919]) begin
      nfail++; $display("FAIL frame_last got %0d LAST flags want 1 at output 1920", nlast());
    end
    ncmp++;
    if (FRAME_CNT !== 16'd1 || err_cnt !== 0) begin
      nfail++; $display("FAIL frame_cnt got cnt=%0d err=%0d want cnt=1 err=0", FRAME_CNT, err_cnt);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    send(-16'sd32768, 1'b0); send(16'sd32767, 1'b0); send(16'sd0, 1'b0);
    drain();
    ncmp++;
    if (qat(0) !== -16'sd32768) begin
      nfail++; $display("FAIL sat_sof got %0d want -32768", qat(0));
    end
    ncmp++;
    if (qat(1) !== 16'sd32767) begin
      nfail++; $display("FAIL sat_pos got %0d want 32767", qat(1));
    end
    ncmp++;
    if (qat(2) !== -16'sd30720) begin
      nfail++; $display("FAIL sat_none got %0d want -30720", qat(2));
    end
    do_reset();
    send(16'sd32767, 1'b0); send(-16'sd32768, 1'b0);
    drain();
    ncmp++;
    if (qat(0) !== 16'sd32767 || qat(1) !== -16'sd32768) begin
      nfail++; $display("FAIL sat_neg got %0d,%0d want 32767,-32768", qat(0), qat(1));
    end
  endtask

  // Inputs 160*k give outputs 150+10*k (k = 1..10).
  task automatic test_back_to_back();
    int bad = 0;
    do_reset();
    fork
      for (int k = 1; k <= 10; k++) send(16'(160 * k), k == 10);
      begin
        repeat (4) @(negedge ACLK);
        OUT_READY = 1'b0;
        repeat (5) begin
          @(posedge ACLK); #1;
          ncmp++;
          if (OUT_VALID !== 1'b1 || IN_READY !== 1'b0 || OUT_SAMPLE !== 16'(160 + 10 * oq.size())) begin
            nfail++;
            $display("FAIL stall_hold got vld=%b rdy=%b y=%0d want vld=1 rdy=0 y=%0d",
                     OUT_VALID, IN_READY, OUT_SAMPLE, 160 + 10 * oq.size());
          end
        end
        @(negedge ACLK);
        OUT_READY = 1'b1;
      end
    join
    drain();
    for (int k = 1; k <= 10; k++) if (qat(k - 1) !== 16'(150 + 10 * k)) bad++;
    ncmp++;
    if (oq.size() !== 10 || bad !== 0) begin
      nfail++; $display("FAIL stall_stream got n=%0d bad=%0d want n=10 bad=0", oq.size(), bad);
    end
    ncmp++;
    if (nlast() !== 1 || !lq[lq.size()-1] || FRAME_CNT !== 16'd1 || err_cnt !== 1) begin
      nfail++; $display("FAIL stall_frame got last=%0d cnt=%0d err=%0d want 1,1,1", nlast(), FRAME_CNT, err_cnt);
    end
  endtask

  task automatic test_short_frame();
    do_reset();
    for (int i = 1; i <= 100; i++) send(16'sd1600, i == 100);
    send(16'sd1600, 1'b0);
    drain();
    ncmp++;
    if (oq.size() !== 101 || qat(99) !== 16'sd100 || !lq[99] || nlast() !== 1) begin
      nfail++; $display("FAIL short_last got n=%0d y99=%0d last=%0d want n=101 y99=100 last=1", oq.size(), qat(99), nlast());
    end
    ncmp++;
    if (err_cnt !== 1) begin
      nfail++; $display("FAIL short_err got %0d pulses want 1", err_cnt);
    end
    ncmp++;
    if (qat(100) !== 16'sd1600 || FRAME_CNT !== 16'd1) begin
      nfail++; $display("FAIL short_sof got y100=%0d cnt=%0d want 1600,1", qat(100), FRAME_CNT);
    end
  endtask

  task automatic test_missing_last();
    do_reset();
    for (int i = 1; i <= 1921; i++) send(16'sd1600, 1'b0);
    drain();
    ncmp++;
    if (oq.size() !== 1921 || !lq[1919] || nlast() !== 1) begin
      nfail++; $display("FAIL miss_last got n=%0d last=%0d want n=1921 last=1 at 1920", oq.size(), nlast());
    end
    ncmp++;
    if (err_cnt !== 1) begin
      nfail++; $display("FAIL miss_err got %0d pulses want 1", err_cnt);
    end
    ncmp++;
    if (qat(1919) !== 16'sd100 || qat(1920) !== 16'sd1600 || FRAME_CNT !== 16'd1) begin
      nfail++; $display("FAIL miss_sof got y1919=%0d y1920=%0d cnt=%0d want 100,1600,1", qat(1919), qat(1920), FRAME_CNT);
    end
  endtask

  initial begin
    ARESET = 1'b1; IN_VALID = 1'b0; IN_SAMPLE = '0; IN_LAST = 1'b0; OUT_READY = 1'b1;
    test_reset();
    test_reset_mid();
    test_full_frame();
    test_saturation();
    test_back_to_back();
    test_short_frame();
    test_missing_last();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
